s_muldiv: RTL and testbench
===========================

Name: s_muldiv

Overview:
- Multi-cycle multiply/divide unit for the SPC700 CPU in the APU; executes MUL YA and DIV YA,X.
- Sits beside the single-cycle s_alu. The CPU control sequencer issues a start, stalls on busy, then writes A, Y and the PSW flags from this block's outputs when done pulses.
- MUL is shift-add. DIV is a 16-step restoring divider that reproduces the SPC700's out-of-range quotient behaviour bit-exactly.

Parameters:
- none (widths are fixed by the SPC700 architecture)

Ports:
- clk      input   1  system clock
- reset_n  input   1  synchronous reset, active-low
- start    input   1  op request; accepted only in IDLE
- op_div   input   1  0 = MUL YA, 1 = DIV YA,X; sampled with start
- a_in     input   8  A register
- y_in     input   8  Y register
- x_in     input   8  X register (DIV only)
- busy     output  1  high in MUL, DIV and DONE states
- done     output  1  one-cycle pulse; results valid
- a_out    output  8  new A
- y_out    output  8  new Y
- n_flg    output  1  N flag result
- z_flg    output  1  Z flag result
- v_flg    output  1  V flag result (DIV)
- h_flg    output  1  H flag result (DIV)
- vh_wr    output  1  1 when V/H must be written (operation was DIV); 0 for MUL

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low: reset_n sampled low on a clk edge resets the block.
  - All outputs and internal registers reset to 0; state resets to IDLE.
  - reset_n low mid-operation aborts: IDLE, busy=0, done=0 and outputs 0 on the following cycle.
- State machine: IDLE -> MUL (8 cycles) or DIV (16 cycles) -> DONE (1 cycle) -> IDLE.
  - start=1 in IDLE at cycle T: operands latched; busy=1 from T+1.
  - MUL: done=1 at T+9. DIV: done=1 at T+17.
  - busy is also high during DONE and drops in the cycle after done.
  - start in any non-IDLE state, including DONE, is ignored. No queueing.
  - A new start is accepted in the cycle after DONE.
- Output timing:
  - a_out, y_out and the flag outputs are registered, updated on entry to DONE, and held until the next completion or reset.
- MUL:
  - P = y*a (16-bit, unsigned), computed by 8 shift-add steps on the 8-bit multiplier.
  - y_out = P[15:8], a_out = P[7:0].
  - n_flg = y_out[7]; z_flg = (y_out == 0). Flags come from Y only.
  - v_flg = h_flg = vh_wr = 0.
- DIV, with YA = {y,a}:
  - Flags computed from the latched operands at start:
    - v_flg = (y >= x)
    - h_flg = (y[3:0] >= x[3:0])
  - Operand selection, fixed at start:
    - If y < 2*x (9-bit compare): dividend D = YA, divisor S = {1'b0, x}.
    - Else: D = YA - {x, 9'b0}, which is 16-bit and never negative in this case; S = 9'd256 - x, range 1..256.
  - Divider: 16-step restoring, one quotient bit per cycle MSB first, 9-bit divisor, 10-bit partial remainder. Q is 16 bits, R is 9 bits.
  - Normal case: a_out = Q[7:0], y_out = R[7:0]. Q may reach 511; bit 8 is dropped.
  - Else case: a_out = 8'd255 - Q[7:0], y_out = x + R[7:0], both mod 256.
  - x = 0 always falls into the else case (S = 256); no division by zero occurs.
  - n_flg = a_out[7]; z_flg = (a_out == 0); vh_wr = 1.
- Input stability: operand inputs are don't-care after the start cycle.

Test Plan:
- MUL: a=0x34, y=0x12, start at T -> done at T+9; y_out=0x03, a_out=0xA8; N=0, Z=0, vh_wr=0; busy high T+1..T+9.
- MUL: a=0xFF, y=0xFF -> y_out=0xFE, a_out=0x01, N=1, Z=0. Then a=0x00, y=0x55 -> 0x0000, Z=1, N=0.
- DIV normal: y=0x12, a=0x34, x=0x56 -> done at T+17; a_out=0x36, y_out=0x10; V=0, H=0, N=0, Z=0, vh_wr=1.
- DIV overflow: y=0xFF, a=0x00, x=0x01 -> a_out=0x02, y_out=0xFE; V=1, H=1, N=0, Z=0.
- DIV by zero: y=0x12, a=0x34, x=0x00 -> a_out=0xED, y_out=0x34; V=1, H=1, N=1, Z=0.
- Control, run as separate sub-cases:
  - start re-asserted during DIV and again in DONE -> no extra done; outputs unchanged.
  - reset_n low at T+5 of a DIV -> busy=0, done=0 and all outputs 0 on the next cycle; no done pulse follows.
  - start issued the cycle after done -> accepted.

Source files
------------

// File: rtl/s_muldiv.sv
// s_muldiv: multi-cycle MUL YA / DIV YA,X unit for the SPC700 core.
// MUL is an 8-step shift-add. DIV is a 16-step restoring divider that
// reproduces the SPC700 out-of-range quotient behaviour bit-exactly.
module s_muldiv (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       op_div,
    input  logic [7:0] a_in,
    input  logic [7:0] y_in,
    input  logic [7:0] x_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] a_out,
    output logic [7:0] y_out,
    output logic       n_flg,
    output logic       z_flg,
    output logic       v_flg,
    output logic       h_flg,
    output logic       vh_wr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [3:0]  r_cnt;
    // multiply datapath
    logic [15:0] r_acc;
    logic [15:0] r_mc;
    logic [7:0]  r_mp;
    // divide datapath: r_dq shifts the dividend out at the top and the
    // quotient in at the bottom, so after 16 steps it holds Q
    logic [15:0] r_dq;
    logic [9:0]  r_rem;
    logic [8:0]  r_div_s;
    logic [7:0]  r_x;
    logic        r_else;
    logic        r_v;
    logic        r_h;

    // registered results
    logic [7:0]  r_a_out;
    logic [7:0]  r_y_out;
    logic        r_n;
    logic        r_z;
    logic        r_vf;
    logic        r_hf;
    logic        r_vh_wr;

    // start-time operand selection for DIV
    logic        w_else_sel;
    logic [15:0] w_d_else;
    logic [8:0]  w_s_else;

    // per-step datapath
    logic [15:0] w_mul_acc;
    logic [9:0]  w_rem_sh;
    logic        w_rem_ge;
    logic [9:0]  w_rem_nx;
    logic [15:0] w_q_nx;
    logic [7:0]  w_div_a;
    logic [7:0]  w_div_y;
    logic        w_last_mul;
    logic        w_last_div;

    // y >= 2x selects the out-of-range path; then x <= 127, so x*512 fits 16 bits
    assign w_else_sel = ({1'b0, y_in} >= {x_in, 1'b0});
    assign w_d_else   = {y_in, a_in} - {x_in[6:0], 9'b0_0000_0000};
    assign w_s_else   = 9'd256 - {1'b0, x_in};

    assign w_last_mul = (r_state == ST_MUL) && (r_cnt == 4'd7);
    assign w_last_div = (r_state == ST_DIV) && (r_cnt == 4'd15);

    // one shift-add step and one restoring-divide step, plus DIV result fix-up
    always_comb begin
        w_mul_acc = r_acc;
        w_rem_sh  = {r_rem[8:0], r_dq[15]};
        w_rem_ge  = (w_rem_sh >= {1'b0, r_div_s});
        w_rem_nx  = w_rem_sh;
        w_q_nx    = {r_dq[14:0], w_rem_ge};
        w_div_a   = w_q_nx[7:0];
        w_div_y   = w_rem_nx[7:0];
        if (r_mp[0]) begin
            w_mul_acc = r_acc + r_mc;
        end else begin
            w_mul_acc = r_acc;
        end
        if (w_rem_ge) begin
            w_rem_nx = w_rem_sh - {1'b0, r_div_s};
        end else begin
            w_rem_nx = w_rem_sh;
        end
        if (r_else) begin
            w_div_a = 8'd255 - w_q_nx[7:0];
            w_div_y = r_x + w_rem_nx[7:0];
        end else begin
            w_div_a = w_q_nx[7:0];
            w_div_y = w_rem_nx[7:0];
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // next-state logic: fixed-length MUL/DIV, single DONE cycle, start only in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = op_div ? ST_DIV : ST_MUL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (w_last_mul) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_MUL;
                end
            end
            ST_DIV: begin
                if (w_last_div) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_DIV;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                done = 1'b0;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // operand latch and iterative datapath
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= 4'd0;
            r_acc   <= 16'd0;
            r_mc    <= 16'd0;
            r_mp    <= 8'd0;
            r_dq    <= 16'd0;
            r_rem   <= 10'd0;
            r_div_s <= 9'd0;
            r_x     <= 8'd0;
            r_else  <= 1'b0;
            r_v     <= 1'b0;
            r_h     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt  <= 4'd0;
                        r_acc  <= 16'd0;
                        r_mc   <= {8'd0, a_in};
                        r_mp   <= y_in;
                        r_rem  <= 10'd0;
                        r_x    <= x_in;
                        r_v    <= (y_in >= x_in);
                        r_h    <= (y_in[3:0] >= x_in[3:0]);
                        r_else <= w_else_sel;
                        if (w_else_sel) begin
                            r_dq    <= w_d_else;
                            r_div_s <= w_s_else;
                        end else begin
                            r_dq    <= {y_in, a_in};
                            r_div_s <= {1'b0, x_in};
                        end
                    end else begin
                        r_cnt <= 4'd0;
                    end
                end
                ST_MUL: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_acc <= w_mul_acc;
                    r_mc  <= {r_mc[14:0], 1'b0};
                    r_mp  <= {1'b0, r_mp[7:1]};
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + 4'd1;
                    r_dq  <= w_q_nx;
                    r_rem <= w_rem_nx;
                end
                ST_DONE: r_cnt <= 4'd0;
                default: r_cnt <= 4'd0;
            endcase
        end
    end

    // result registers: loaded on entry to DONE, held until next completion
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a_out <= 8'd0;
            r_y_out <= 8'd0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_vf    <= 1'b0;
            r_hf    <= 1'b0;
            r_vh_wr <= 1'b0;
        end else if (w_last_mul) begin
            r_a_out <= w_mul_acc[7:0];
            r_y_out <= w_mul_acc[15:8];
            r_n     <= w_mul_acc[15];
            r_z     <= (w_mul_acc[15:8] == 8'd0);
            r_vf    <= 1'b0;
            r_hf    <= 1'b0;
            r_vh_wr <= 1'b0;
        end else if (w_last_div) begin
            r_a_out <= w_div_a;
            r_y_out <= w_div_y;
            r_n     <= w_div_a[7];
            r_z     <= (w_div_a == 8'd0);
            r_vf    <= r_v;
            r_hf    <= r_h;
            r_vh_wr <= 1'b1;
        end else begin
            r_a_out <= r_a_out;
            r_y_out <= r_y_out;
            r_n     <= r_n;
            r_z     <= r_z;
            r_vf    <= r_vf;
            r_hf    <= r_hf;
            r_vh_wr <= r_vh_wr;
        end
    end

    assign a_out = r_a_out;
    assign y_out = r_y_out;
    assign n_flg = r_n;
    assign z_flg = r_z;
    assign v_flg = r_vf;
    assign h_flg = r_hf;
    assign vh_wr = r_vh_wr;

endmodule

// File: tb/tb_s_muldiv.sv
// Directed self-checking bench for s_muldiv.
module tb_s_muldiv;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       op_div;
    logic [7:0] a_in;
    logic [7:0] y_in;
    logic [7:0] x_in;
    logic       busy;
    logic       done;
    logic [7:0] a_out;
    logic [7:0] y_out;
    logic       n_flg;
    logic       z_flg;
    logic       v_flg;
    logic       h_flg;
    logic       vh_wr;

    int total;
    int bad;

    s_muldiv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op_div  (op_div),
        .a_in    (a_in),
        .y_in    (y_in),
        .x_in    (x_in),
        .busy    (busy),
        .done    (done),
        .a_out   (a_out),
        .y_out   (y_out),
        .n_flg   (n_flg),
        .z_flg   (z_flg),
        .v_flg   (v_flg),
        .h_flg   (h_flg),
        .vh_wr   (vh_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // result vector: {y_out, a_out, n, z, v, h, vh_wr}
    function automatic logic [20:0] res_vec();
        return {y_out, a_out, n_flg, z_flg, v_flg, h_flg, vh_wr};
    endfunction

    // drive one start cycle; returns 1 time unit after the accepting edge (cycle T)
    task automatic issue(input logic op, input logic [7:0] a, input logic [7:0] y,
                         input logic [7:0] x);
        @(negedge clk);
        start  = 1'b1;
        op_div = op;
        a_in   = a;
        y_in   = y;
        x_in   = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 8'hA5;
        y_in  = 8'h5A;
        x_in  = 8'hC3;
    endtask

    // count negedges after cycle T until done; k = -1 on timeout
    task automatic wait_done(input int k0, output int k);
        k = k0;
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done === 1'b1) return;
        end
        k = -1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        op_div  = 1'b0;
        a_in    = 8'h00;
        y_in    = 8'h00;
        x_in    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, res_vec()} !== 23'd0) begin
            bad++;
            $display("FAIL reset_state got %h want 0", {busy, done, res_vec()});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_mul();
        int nbusy;
        int ndone;
        int k;
        // 0x12 * 0x34 = 0x03A8; check busy/done window cycle by cycle
        issue(1'b0, 8'h34, 8'h12, 8'h00);
        nbusy = 0;
        ndone = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (busy !== (i <= 9)) nbusy++;
            if (done !== (i == 9)) ndone++;
            if (i == 9) begin
                total++;
                if (res_vec() !== {8'h03, 8'hA8, 5'b00000}) begin
                    bad++;
                    $display("FAIL mul_1234 got %h want %h", res_vec(), {8'h03, 8'hA8, 5'b00000});
                end
            end
        end
        total++;
        if (nbusy != 0) begin
            bad++;
            $display("FAIL mul_busy_window got %0d bad cycles want 0", nbusy);
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL mul_done_timing got %0d bad cycles want 0", ndone);
        end
        // 0xFF * 0xFF = 0xFE01, N=1
        issue(1'b0, 8'hFF, 8'hFF, 8'h00);
        wait_done(0, k);
        total++;
        if (k !== 9) begin
            bad++;
            $display("FAIL mul_ff_latency got %0d want 9", k);
        end
        total++;
        if (res_vec() !== {8'hFE, 8'h01, 5'b10000}) begin
            bad++;
            $display("FAIL mul_ffff got %h want %h", res_vec(), {8'hFE, 8'h01, 5'b10000});
        end
        // 0x55 * 0x00 = 0, Z=1
        issue(1'b0, 8'h00, 8'h55, 8'h00);
        wait_done(0, k);
        total++;
        if (res_vec() !== {8'h00, 8'h00, 5'b01000} || k !== 9) begin
            bad++;
            $display("FAIL mul_zero got %h k=%0d want %h k=9", res_vec(), k, {8'h00, 8'h00, 5'b01000});
        end
    endtask

    task automatic test_div();
        int k;
        // normal: 0x1234 / 0x56 = 0x36 r 0x10
        issue(1'b1, 8'h34, 8'h12, 8'h56);
        wait_done(0, k);
        total++;
        if (k !== 17) begin
            bad++;
            $display("FAIL div_latency got %0d want 17", k);
        end
        total++;
        if (res_vec() !== {8'h10, 8'h36, 5'b00001}) begin
            bad++;
            $display("FAIL div_normal got %h want %h", res_vec(), {8'h10, 8'h36, 5'b00001});
        end
        // overflow: YA=0xFF00, X=1
        issue(1'b1, 8'h00, 8'hFF, 8'h01);
        wait_done(0, k);
        total++;
        if (res_vec() !== {8'hFE, 8'h02, 5'b00111} || k !== 17) begin
            bad++;
            $display("FAIL div_overflow got %h k=%0d want %h k=17", res_vec(), k, {8'hFE, 8'h02, 5'b00111});
        end
        // divide by zero: YA=0x1234, X=0
        issue(1'b1, 8'h34, 8'h12, 8'h00);
        wait_done(0, k);
        total++;
        if (res_vec() !== {8'h34, 8'hED, 5'b10111} || k !== 17) begin
            bad++;
            $display("FAIL div_by_zero got %h k=%0d want %h k=17", res_vec(), k, {8'h34, 8'hED, 5'b10111});
        end
    endtask

    task automatic test_ignore_start();
        int k;
        int ndone;
        issue(1'b1, 8'h34, 8'h12, 8'h56);
        repeat (3) @(negedge clk);
        start  = 1'b1;
        op_div = 1'b0;
        a_in   = 8'hFF;
        y_in   = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3, k);
        total++;
        if (k !== 17 || res_vec() !== {8'h10, 8'h36, 5'b00001}) begin
            bad++;
            $display("FAIL ignore_in_div got %h k=%0d want %h k=17", res_vec(), k, {8'h10, 8'h36, 5'b00001});
        end
        // start while in DONE
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) ndone++;
        end
        total++;
        if (ndone != 0 || res_vec() !== {8'h10, 8'h36, 5'b00001}) begin
            bad++;
            $display("FAIL ignore_in_done got %0d active cycles res=%h want 0 res=%h", ndone, res_vec(),
                     {8'h10, 8'h36, 5'b00001});
        end
    endtask

    task automatic test_back_to_back();
        int k;
        issue(1'b1, 8'h00, 8'hFF, 8'h01);
        wait_done(0, k);
        // issue() starts on the next negedge: the cycle right after DONE
        issue(1'b0, 8'h34, 8'h12, 8'h00);
        wait_done(0, k);
        total++;
        if (k !== 9 || res_vec() !== {8'h03, 8'hA8, 5'b00000}) begin
            bad++;
            $display("FAIL back_to_back got %h k=%0d want %h k=9", res_vec(), k, {8'h03, 8'hA8, 5'b00000});
        end
    endtask

    task automatic test_abort();
        int ndone;
        issue(1'b1, 8'h34, 8'h12, 8'h56);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, res_vec()} !== 23'd0) begin
            bad++;
            $display("FAIL abort_clear got %h want 0", {busy, done, res_vec()});
        end
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) ndone++;
        end
        total++;
        if (ndone != 0) begin
            bad++;
            $display("FAIL abort_no_done got %0d active cycles want 0", ndone);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_mul();
        test_div();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
